// File: rtl/fp_addsub_pipe.sv
`timescale 1ns/1ps
// Pipelined IEEE-754 add/sub, RNE, subnormals; FP_ADD_FLAGS_EN adds the {invalid,overflow,underflow,inexact} flags port.
// Latency: 4 cycles accept-to-out_valid, 1 op/cycle.
// Backpressure: one global stall, in_ready = !out_valid || out_ready, so all stages hold while output is blocked.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result
`ifdef FP_ADD_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;          // hidden, mantissa, guard, round, sticky
    localparam int LZW = $clog2(FW + 1);
    localparam int CW  = ((LZW > EXP_W) ? LZW : EXP_W) + 2;
    localparam logic [CW-1:0] EXP_MAX = CW'((1 << EXP_W) - 1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rstn;

    // ---------------- S1: unpack, classify, swap ----------------
    logic             a_sgn, b_sgn, l_sgn, s_sgn;
    logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, l_eff, s_eff;
    logic [MAN_W-1:0] a_man, b_man, l_man, s_man;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic             sp_hit;
    logic [W-1:0]     sp_res, qnan;

    always_comb begin
        a_sgn  = op_a[W-1];
        a_exp  = op_a[W-2:MAN_W];
        a_man  = op_a[MAN_W-1:0];
        b_sgn  = op_b[W-1] ^ sub;
        b_exp  = op_b[W-2:MAN_W];
        b_man  = op_b[MAN_W-1:0];
        a_nan  = (&a_exp) & (|a_man);
        b_nan  = (&b_exp) & (|b_man);
        a_inf  = (&a_exp) & ~(|a_man);
        b_inf  = (&b_exp) & ~(|b_man);
        a_zero = ~(|a_exp) & ~(|a_man);
        b_zero = ~(|b_exp) & ~(|b_man);
        // Biased-exponent/mantissa field order is monotonic in magnitude, subnormals included.
        a_big  = (op_a[W-2:0] >= op_b[W-2:0]);
        if (a_big) begin
            l_sgn = a_sgn; l_exp = a_exp; l_man = a_man;
            s_sgn = b_sgn; s_exp = b_exp; s_man = b_man;
        end else begin
            l_sgn = b_sgn; l_exp = b_exp; l_man = b_man;
            s_sgn = a_sgn; s_exp = a_exp; s_man = a_man;
        end
        l_eff = (l_exp == '0) ? EXP_W'(1) : l_exp;
        s_eff = (s_exp == '0) ? EXP_W'(1) : s_exp;
    end

`ifdef FP_ADD_FLAGS_EN
    logic sp_inv;
`endif

    always_comb begin
        qnan              = '0;
        qnan[W-2:MAN_W]   = '1;
        qnan[MAN_W-1]     = 1'b1;
        sp_hit            = 1'b1;
        sp_res            = qnan;
`ifdef FP_ADD_FLAGS_EN
        sp_inv            = 1'b0;
`endif
        if (a_nan | b_nan) begin
`ifdef FP_ADD_FLAGS_EN
            sp_inv = (a_nan & ~a_man[MAN_W-1]) | (b_nan & ~b_man[MAN_W-1]);
`endif
        end else if (a_inf & b_inf & (a_sgn != b_sgn)) begin
`ifdef FP_ADD_FLAGS_EN
            sp_inv = 1'b1;
`endif
        end else if (a_inf) begin
            sp_res = {a_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sp_res = {b_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero & b_zero) begin
            // Only (-0)+(-0) keeps the sign; mixed-sign zeros give +0.
            sp_res = {a_sgn & b_sgn, {(W-1){1'b0}}};
        end else if (a_zero) begin
            sp_res = {b_sgn, op_b[W-2:0]};
        end else if (b_zero) begin
            sp_res = op_a;
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic             s1_vld, s1_sgn, s1_esub, s1_sp;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [MAN_W:0]   s1_lsig, s1_ssig;
    logic [W-1:0]     s1_sp_res;

    // ---------------- S2: align smaller significand ----------------
    logic [FW-1:0] al_ext, al_mask, al_shr, al_small;

    always_comb begin
        al_ext   = {s1_ssig, 3'b000};
        al_mask  = ~({FW{1'b1}} << s1_diff);
        al_shr   = al_ext >> s1_diff;
        al_small = {al_shr[FW-1:1], al_shr[0] | (|(al_ext & al_mask))};
    end

    logic             s2_vld, s2_sgn, s2_esub, s2_sp;
    logic [EXP_W-1:0] s2_exp;
    logic [FW-1:0]    s2_big, s2_small;
    logic [W-1:0]     s2_sp_res;

    // ---------------- S3: magnitude add/sub ----------------
    logic [FW:0] sum_c;
    assign sum_c = s2_esub ? ({1'b0, s2_big} - {1'b0, s2_small})
                           : ({1'b0, s2_big} + {1'b0, s2_small});

    logic             s3_vld, s3_sgn, s3_esub, s3_sp;
    logic [EXP_W-1:0] s3_exp;
    logic [FW:0]      s3_sum;
    logic [W-1:0]     s3_sp_res;

`ifdef FP_ADD_FLAGS_EN
    logic s1_sp_inv, s2_sp_inv, s3_sp_inv;
`endif

    // ---------------- S4: normalise, round, pack ----------------
    logic [LZW-1:0]   lzc;
    logic             lz_found;
    logic [CW-1:0]    e_in, shamt, e_norm, e_fin;
    logic [FW-1:0]    nrm;
    logic [MAN_W+1:0] rnd;
    logic             g, r, st, lsb, inc, ovf;
    logic [W-1:0]     res_c;

    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (s3_sum[i]) lz_found = 1'b1;
                else           lzc = lzc + LZW'(1);
            end
        end
    end

    always_comb begin
        e_in   = CW'(s3_exp);
        shamt  = '0;
        if (s3_sum[FW]) begin
            nrm    = {s3_sum[FW:2], s3_sum[1] | s3_sum[0]};
            e_norm = e_in + CW'(1);
        end else begin
            // Stop at exponent 1: anything left unnormalised is a subnormal.
            shamt  = (CW'(lzc) < (e_in - CW'(1))) ? CW'(lzc) : (e_in - CW'(1));
            nrm    = s3_sum[FW-1:0] << shamt;
            e_norm = e_in - shamt;
        end
        lsb = nrm[3];
        g   = nrm[2];
        r   = nrm[1];
        st  = nrm[0];
        inc = g & (r | st | lsb);
        rnd = {1'b0, nrm[FW-1:3]} + (MAN_W+2)'(inc);
        if (rnd[MAN_W+1])    e_fin = e_norm + CW'(1);
        else if (rnd[MAN_W]) e_fin = e_norm;
        else                 e_fin = '0;
        ovf = (e_fin >= EXP_MAX);

        if (s3_sp)                res_c = s3_sp_res;
        else if (s3_sum == '0)    res_c = {s3_sgn & ~s3_esub, {(W-1){1'b0}}};
        else if (ovf)             res_c = {s3_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else                      res_c = {s3_sgn, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
    end

`ifdef FP_ADD_FLAGS_EN
    logic [3:0] flg_c;
    logic       inx;
    always_comb begin
        inx = g | r | st;
        if (s3_sp)             flg_c = {s3_sp_inv, 3'b000};
        else if (s3_sum == '0) flg_c = 4'b0000;
        else if (ovf)          flg_c = 4'b0101;
        else                   flg_c = {2'b00, inx & (e_fin == '0), inx};
    end
`endif

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
`ifdef FP_ADD_FLAGS_EN
            flags     <= '0;
`endif
        end else if (advance) begin
            s1_vld    <= in_valid;
            s1_sgn    <= l_sgn;
            s1_esub   <= l_sgn ^ s_sgn;
            s1_exp    <= l_eff;
            s1_diff   <= l_eff - s_eff;
            s1_lsig   <= {|l_exp, l_man};
            s1_ssig   <= {|s_exp, s_man};
            s1_sp     <= sp_hit;
            s1_sp_res <= sp_res;

            s2_vld    <= s1_vld;
            s2_sgn    <= s1_sgn;
            s2_esub   <= s1_esub;
            s2_exp    <= s1_exp;
            s2_big    <= {s1_lsig, 3'b000};
            s2_small  <= al_small;
            s2_sp     <= s1_sp;
            s2_sp_res <= s1_sp_res;

            s3_vld    <= s2_vld;
            s3_sgn    <= s2_sgn;
            s3_esub   <= s2_esub;
            s3_exp    <= s2_exp;
            s3_sum    <= sum_c;
            s3_sp     <= s2_sp;
            s3_sp_res <= s2_sp_res;

            out_valid <= s3_vld;
            if (s3_vld) result <= res_c;
`ifdef FP_ADD_FLAGS_EN
            s1_sp_inv <= sp_inv;
            s2_sp_inv <= s1_sp_inv;
            s3_sp_inv <= s2_sp_inv;
            if (s3_vld) flags <= flg_c;
`endif
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_addsub_pipe: single precision instance plus a half precision instance.
module tb_fp_addsub_pipe;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [31:0] acc;
        logic        chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        sp_in_valid = 1'b0, sp_in_ready, sp_sub = 1'b0, sp_out_valid, sp_out_ready = 1'b1;
    logic [31:0] sp_op_a = '0, sp_op_b = '0, sp_result;
    logic        hp_in_valid = 1'b0, hp_in_ready, hp_sub = 1'b0, hp_out_valid, hp_out_ready = 1'b1;
    logic [15:0] hp_op_a = '0, hp_op_b = '0, hp_result;
`ifdef FP_ADD_FLAGS_EN
    logic [3:0]  sp_flags, hp_flags;
`endif

    fp_addsub_pipe dut_sp (
        .clk(clk), .rstn(rstn), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .op_a(sp_op_a), .op_b(sp_op_b), .sub(sp_sub),
        .out_valid(sp_out_valid), .out_ready(sp_out_ready), .result(sp_result)
`ifdef FP_ADD_FLAGS_EN
        , .flags(sp_flags)
`endif
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk(clk), .rstn(rstn), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
        .op_a(hp_op_a), .op_b(hp_op_b), .sub(hp_sub),
        .out_valid(hp_out_valid), .out_ready(hp_out_ready), .result(hp_result)
`ifdef FP_ADD_FLAGS_EN
        , .flags(hp_flags)
`endif
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;
    exp_t        q_sp[$];
    exp_t        q_hp[$];
    exp_t        sp_e, hp_e;
    logic        lat_mode = 1'b1;
    logic        push_en = 1'b1;
    logic [31:0] sp_hold = '0;
    logic        sp_held = 1'b0;
    logic [31:0] st_a[8], st_b[8], st_r[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        total++;
        bad++;
        $display("FAIL %s: observed %0d", name, val);
    endtask

    // Monitors: pop the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rstn && sp_out_valid) begin
            if (sp_out_ready) begin
                sp_held = 1'b0;
                if (q_sp.size() == 0) fail_now("sp_unexpected_output", int'(sp_result));
                else begin
                    sp_e = q_sp.pop_front();
                    check("sp_result", sp_result, sp_e.res);
`ifdef FP_ADD_FLAGS_EN
                    check("sp_flags", 32'(sp_flags), 32'(sp_e.flg));
`endif
                    if (sp_e.chk_lat) check("sp_latency", cyc - sp_e.acc, 32'd4);
                end
            end else begin
                if (sp_held) check("sp_hold_stable", sp_result, sp_hold);
                sp_hold = sp_result;
                sp_held = 1'b1;
            end
        end else begin
            sp_held = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rstn && hp_out_valid && hp_out_ready) begin
            if (q_hp.size() == 0) fail_now("hp_unexpected_output", int'(hp_result));
            else begin
                hp_e = q_hp.pop_front();
                check("hp_result", 32'(hp_result), hp_e.res);
`ifdef FP_ADD_FLAGS_EN
                check("hp_flags", 32'(hp_flags), 32'(hp_e.flg));
`endif
                if (hp_e.chk_lat) check("hp_latency", cyc - hp_e.acc, 32'd4);
            end
        end
    end

    task automatic issue(input logic hp, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic [3:0] ef);
        int n = 0;
        if (hp) begin
            hp_op_a = a[15:0]; hp_op_b = b[15:0]; hp_sub = s; hp_in_valid = 1'b1;
        end else begin
            sp_op_a = a; sp_op_b = b; sp_sub = s; sp_in_valid = 1'b1;
        end
        @(negedge clk);
        while (!(hp ? hp_in_ready : sp_in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("issue_timeout", n);
        else if (push_en) begin
            if (hp) q_hp.push_back('{res: er, flg: ef, acc: cyc, chk_lat: lat_mode});
            else    q_sp.push_back('{res: er, flg: ef, acc: cyc, chk_lat: lat_mode});
        end
        @(posedge clk);
        #1;
        sp_in_valid = 1'b0;
        hp_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_sp.size() != 0 || q_hp.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("drain_timeout_pending", q_sp.size() + q_hp.size());
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_a = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40800000, 32'h40800000, 32'h41000000};
        st_b = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
        st_r = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(sp_out_valid), 32'd0);
        check("rst_result", sp_result, 32'd0);
`ifdef FP_ADD_FLAGS_EN
        check("rst_flags", 32'(sp_flags), 32'd0);
`endif
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(sp_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed single precision vectors, back to back
        issue(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000);
        issue(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'b0000);
        issue(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000);
        issue(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001);
        issue(0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'b0001);
        issue(0, 32'h3F800000, 32'h33800001, 0, 32'h3F800001, 4'b0001);
        issue(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'b1000);
        issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101);
        issue(0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000);
        issue(0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b0000);
        issue(0, 32'h7F800000, 32'h3F800000, 1, 32'h7F800000, 4'b0000);
        issue(0, 32'h00000001, 32'h00000001, 0, 32'h00000002, 4'b0000);
        issue(0, 32'h00800000, 32'h00000001, 1, 32'h007FFFFF, 4'b0000);
        issue(0, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 4'b0000);
        issue(0, 32'h3F800000, 32'h40000000, 1, 32'hBF800000, 4'b0000);
        issue(0, 32'hBF800000, 32'h3F000000, 0, 32'hBF000000, 4'b0000);
        issue(0, 32'h00000000, 32'h40000000, 1, 32'hC0000000, 4'b0000);
        issue(0, 32'h80000000, 32'h00000000, 0, 32'h00000000, 4'b0000);
        drain();

        // Backpressure: 8 ops streamed while the output is blocked for 6 cycles
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(0, st_a[i], st_b[i], 0, st_r[i], 4'b0000);
            end
            begin
                sp_out_ready = 1'b0;
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(sp_in_ready), 32'd0);
                @(posedge clk);
                #1 sp_out_ready = 1'b1;
            end
        join
        drain();
        lat_mode = 1'b1;

        // Reset with operations in flight: nothing may emerge afterwards
        push_en = 1'b0;
        issue(0, 32'h3F800000, 32'h3F800000, 0, 32'h0, 4'b0000);
        issue(0, 32'h40000000, 32'h40000000, 0, 32'h0, 4'b0000);
        issue(0, 32'h40400000, 32'h40400000, 0, 32'h0, 4'b0000);
        rstn = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(sp_out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1 push_en = 1'b1;

        // Half precision
        issue(1, 32'h3C00, 32'h4000, 0, 32'h4200, 4'b0000);
        issue(1, 32'h4200, 32'h3C00, 1, 32'h4000, 4'b0000);
        issue(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 4'b0101);
        issue(1, 32'h0001, 32'h0001, 0, 32'h0002, 4'b0000);
        issue(1, 32'h7C00, 32'hFC00, 0, 32'h7E00, 4'b1000);
        issue(1, 32'h3C00, 32'h3C00, 1, 32'h0000, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
